multiciclo_core: RTL and testbench

MULTICICLO_CORE -- requirements
Module: multiciclo_core

---
 rtl/multiciclo_core_if.sv | 25 ++
 rtl/multiciclo_core.sv | 154 +++++++++++++++
 tb/tb_multiciclo_core.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multiciclo_core_if.sv
// Instruction/result bus of multiciclo_core: valid/ready instruction handshake,
// load-data input and the registered execution results.
interface multiciclo_core_if #(
    parameter int WIDTH = 32
);
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instruction;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             done;
    logic             branch_taken;
    logic             illegal;

    modport master (
        output instr_valid, instruction, write_data,
        input  instr_ready, ALUResult, Zero, done, branch_taken, illegal
    );

    modport slave (
        input  instr_valid, instruction, write_data,
        output instr_ready, ALUResult, Zero, done, branch_taken, illegal
    );
endinterface

// File: rtl/multiciclo_core.sv
// Multi-cycle MIPS subset core (add/sub/and/or/slt, addi, lw, beq) driven by an
// IDLE/DECODE/EXEC/MEM/WB control FSM with a valid/ready instruction port.
module multiciclo_core #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input logic              clk,
    input logic              rst,
    multiciclo_core_if.slave bus
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

    state_t           state, state_next;
    logic [31:0]      ir;
    logic [WIDTH-1:0] reg_a, reg_b, load_reg, alu_q, alu_next, imm_ext, wb_val;
    logic             zero_q, done_q, illegal_q, taken_q;
    logic [WIDTH-1:0] regs [NREGS];
    logic [5:0]       opcode, funct;
    logic [AW-1:0]    rs_idx, rt_idx, rd_idx, wb_idx;
    logic             is_rtype, rtype_ok, is_addi, is_lw, is_beq, supported, done_next;
    logic             unused_shamt;

    assign opcode       = ir[31:26];
    assign funct        = ir[5:0];
    assign rs_idx       = ir[21 +: AW];
    assign rt_idx       = ir[16 +: AW];
    assign rd_idx       = ir[11 +: AW];
    assign imm_ext      = WIDTH'($signed(ir[15:0]));
    assign unused_shamt = ^ir[10:6];

    assign is_rtype  = (opcode == OP_RTYPE);
    assign rtype_ok  = is_rtype && (funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
    assign is_addi   = (opcode == OP_ADDI);
    assign is_lw     = (opcode == OP_LW);
    assign is_beq    = (opcode == OP_BEQ);
    assign supported = rtype_ok || is_addi || is_lw || is_beq;

    assign wb_idx = is_rtype ? rd_idx : rt_idx;
    assign wb_val = is_lw ? load_reg : alu_q;

    assign bus.instr_ready  = (state == IDLE) && !rst;
    assign bus.ALUResult    = alu_q;
    assign bus.Zero         = zero_q;
    assign bus.done         = done_q;
    assign bus.branch_taken = taken_q;
    assign bus.illegal      = illegal_q;

    // ALU: addi and lw share the base+offset path, beq compares via subtraction
    always_comb begin
        alu_next = reg_a + imm_ext;
        if (is_rtype) begin
            case (funct)
                FN_SUB:  alu_next = reg_a - reg_b;
                FN_AND:  alu_next = reg_a & reg_b;
                FN_OR:   alu_next = reg_a | reg_b;
                FN_SLT:  alu_next = {{(WIDTH-1){1'b0}}, ($signed(reg_a) < $signed(reg_b))};
                default: alu_next = reg_a + reg_b;
            endcase
        end else if (is_beq) begin
            alu_next = reg_a - reg_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Every path back to IDLE is a completion, so it also raises done next cycle
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE:   if (bus.instr_valid) state_next = DECODE;
            DECODE: begin
                if (supported) begin
                    state_next = EXEC;
                end else begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            EXEC: begin
                if (is_lw) begin
                    state_next = MEM;
                end else if (is_beq) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    state_next = WB;
                end
            end
            MEM:    state_next = WB;
            WB: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath; illegal/branch_taken are only rewritten alongside a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            ir        <= '0;
            reg_a     <= '0;
            reg_b     <= '0;
            load_reg  <= '0;
            alu_q     <= '0;
            zero_q    <= 1'b1;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            taken_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            done_q <= done_next;
            if (state == IDLE && bus.instr_valid) ir <= bus.instruction;
            if (state == DECODE) begin
                reg_a <= regs[rs_idx];
                reg_b <= regs[rt_idx];
                if (!supported) begin
                    illegal_q <= 1'b1;
                    taken_q   <= 1'b0;
                end
            end
            if (state == EXEC) begin
                alu_q  <= alu_next;
                zero_q <= (alu_next == '0);
                if (is_beq) begin
                    illegal_q <= 1'b0;
                    taken_q   <= (alu_next == '0);
                end
            end
            if (state == MEM) load_reg <= bus.write_data;
            if (state == WB) begin
                illegal_q <= 1'b0;
                taken_q   <= 1'b0;
                if (wb_idx != '0) regs[wb_idx] <= wb_val;
            end
        end
    end
endmodule

// File: tb/tb_multiciclo_core.sv
// Testbench for multiciclo_core: directed vector table, protocol/reset sequences
// and randomized instructions checked against an instruction-level model.
module tb_multiciclo_core;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] wd;
        int          lat;
        logic [31:0] alu;
        logic        zero;
        logic        taken;
        logic        illegal;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_mis = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_alu;
    logic        m_zero;

    multiciclo_core_if #(.WIDTH(32)) bus();

    multiciclo_core #(.WIDTH(32), .NREGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] rtype(int rs, int rt, int rd, logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(logic [5:0] op, int rs, int rt, logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    // Instruction-level reference: predicts the visible outcome and commits its effect
    function automatic vec_t model_step(logic [31:0] ins, logic [31:0] wd);
        vec_t        v;
        logic [31:0] a, b, imm, res;
        int          dst;
        bit          legal;
        a       = m_regs[ins[25:21]];
        b       = m_regs[ins[20:16]];
        imm     = {{16{ins[15]}}, ins[15:0]};
        v.ins   = ins;
        v.wd    = wd;
        v.lat   = 4;
        v.taken = 1'b0;
        v.illegal = 1'b0;
        legal   = 1'b1;
        dst     = -1;
        res     = '0;
        case (ins[31:26])
            6'h00: begin
                dst = int'(ins[15:11]);
                case (ins[5:0])
                    6'h20:   res = a + b;
                    6'h22:   res = a - b;
                    6'h24:   res = a & b;
                    6'h25:   res = a | b;
                    6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: legal = 1'b0;
                endcase
            end
            6'h08: begin res = a + imm; dst = int'(ins[20:16]); end
            6'h23: begin res = a + imm; dst = int'(ins[20:16]); v.lat = 5; end
            6'h04: begin res = a - b; v.lat = 3; v.taken = (a == b); end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            v.lat     = 2;
            v.illegal = 1'b1;
            v.alu     = m_alu;
            v.zero    = m_zero;
        end else begin
            m_alu  = res;
            m_zero = (res == 32'd0);
            v.alu  = res;
            v.zero = m_zero;
            if (dst > 0) m_regs[dst] = (ins[31:26] == 6'h23) ? wd : res;
        end
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_alu  = '0;
        m_zero = 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a sample point with the core ready; returns at the done cycle
    task automatic applyStimulus(input vec_t v, input bit hold, input string tag);
        int cyc;
        checkOutput({tag, ".ready"}, 64'(bus.instr_ready), 64'd1);
        bus.instr_valid = 1'b1;
        bus.instruction = v.ins;
        bus.write_data  = v.wd;
        tick();
        cyc = 1;
        if (hold) bus.instruction = 32'hFC00_0000;
        else      bus.instr_valid = 1'b0;
        while (!bus.done && cyc < 20) begin
            tick();
            cyc++;
        end
        bus.instr_valid = 1'b0;
        checkOutput({tag, ".latency"}, 64'(cyc), 64'(v.lat));
        checkOutput({tag, ".alu"}, 64'(bus.ALUResult), 64'(v.alu));
        checkOutput({tag, ".zero"}, 64'(bus.Zero), 64'(v.zero));
        checkOutput({tag, ".taken"}, 64'(bus.branch_taken), 64'(v.taken));
        checkOutput({tag, ".illegal"}, 64'(bus.illegal), 64'(v.illegal));
    endtask

    // Reads a register architecturally through "or r0, rN, r0"
    task automatic check_reg(input int idx, input logic [31:0] exp);
        vec_t v;
        v      = model_step(rtype(idx, 0, 0, FN_OR), 32'd0);
        v.alu  = exp;
        v.zero = (exp == 32'd0);
        applyStimulus(v, 1'b0, $sformatf("r%0d", idx));
    endtask

    initial begin
        vec_t        tbl [12];
        vec_t        v;
        logic [31:0] ins;
        logic [5:0]  fns [5];
        logic [5:0]  bad_ops [3];
        int          k, rs, rt;

        fns     = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
        bad_ops = '{6'h3F, 6'h02, 6'h2B};

        tbl[0]  = '{rtype(0, 0, 3, FN_ADD),       32'd0,         4, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{itype(6'h08, 0, 1, 16'd5),    32'd0,         4, 32'h0000_0005, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{itype(6'h08, 0, 2, 16'hFFF9), 32'd0,         4, 32'hFFFF_FFF9, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{rtype(2, 1, 4, FN_SLT),       32'd0,         4, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{rtype(1, 1, 5, FN_SUB),       32'd0,         4, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{itype(6'h23, 1, 6, 16'd4),    32'hDEADBEEF,  5, 32'h0000_0009, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{itype(6'h04, 1, 1, 16'd0),    32'd0,         3, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{itype(6'h04, 1, 2, 16'd0),    32'd0,         3, 32'h0000_000C, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{32'hFC21_0000,                32'd0,         2, 32'h0000_000C, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{rtype(1, 2, 7, FN_AND),       32'd0,         4, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{rtype(1, 2, 8, FN_OR),        32'd0,         4, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{rtype(1, 2, 9, 6'h21),        32'd0,         2, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b1};

        bus.instr_valid = 1'b0;
        bus.instruction = '0;
        bus.write_data  = '0;
        model_reset();

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        checkOutput("rst.ready", 64'(bus.instr_ready), 64'd0);
        checkOutput("rst.done", 64'(bus.done), 64'd0);
        checkOutput("rst.alu", 64'(bus.ALUResult), 64'd0);
        checkOutput("rst.zero", 64'(bus.Zero), 64'd1);
        checkOutput("rst.illegal", 64'(bus.illegal), 64'd0);
        checkOutput("rst.taken", 64'(bus.branch_taken), 64'd0);
        rst = 1'b0;
        #1;

        // Directed table, issued back-to-back on each done cycle
        for (int i = 0; i < 12; i++) begin
            v = model_step(tbl[i].ins, tbl[i].wd);
            applyStimulus(tbl[i], 1'b0, $sformatf("vec%0d", i));
        end
        tick();
        check_reg(1, 32'h0000_0005);
        check_reg(2, 32'hFFFF_FFF9);
        check_reg(3, 32'h0000_0000);
        check_reg(4, 32'h0000_0001);
        check_reg(5, 32'h0000_0000);
        check_reg(6, 32'hDEADBEEF);
        check_reg(7, 32'h0000_0001);
        check_reg(8, 32'hFFFF_FFFD);
        check_reg(9, 32'h0000_0000);

        // instr_valid held (with a changed word) during execution
        tick();
        v = model_step(itype(6'h08, 0, 10, 16'd3), 32'd0);
        applyStimulus(v, 1'b1, "hold");
        tick();
        checkOutput("hold.no_extra_done", 64'(bus.done), 64'd0);
        checkOutput("hold.ready_after", 64'(bus.instr_ready), 64'd1);
        check_reg(10, 32'd3);

        // Reset while an addi r7 is in EXEC
        tick();
        bus.instr_valid = 1'b1;
        bus.instruction = itype(6'h08, 0, 7, 16'h0055);
        tick();
        bus.instr_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checkOutput("midrst.done", 64'(bus.done), 64'd0);
        checkOutput("midrst.ready", 64'(bus.instr_ready), 64'd0);
        checkOutput("midrst.alu", 64'(bus.ALUResult), 64'd0);
        checkOutput("midrst.zero", 64'(bus.Zero), 64'd1);
        rst = 1'b0;
        #1;
        checkOutput("midrst.ready_after", 64'(bus.instr_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("midrst.idle%0d.done", i), 64'(bus.done), 64'd0);
        end
        model_reset();
        check_reg(7, 32'd0);
        check_reg(1, 32'd0);

        // Randomized instruction mix against the reference model
        for (int n = 0; n < 150; n++) begin
            k  = $urandom_range(0, 9);
            rs = $urandom_range(0, 31);
            rt = ($urandom_range(0, 3) == 0) ? rs : $urandom_range(0, 31);
            case (k)
                0, 1, 2, 3, 4: ins = rtype(rs, rt, $urandom_range(0, 31), fns[k]);
                5: ins = itype(6'h08, rs, rt, 16'($urandom));
                6: ins = itype(6'h23, rs, rt, 16'($urandom));
                7: ins = itype(6'h04, rs, rt, 16'($urandom));
                8: ins = itype(bad_ops[$urandom_range(0, 2)], rs, rt, 16'($urandom));
                default: ins = rtype(rs, rt, $urandom_range(0, 31), 6'h21);
            endcase
            v = model_step(ins, $urandom);
            applyStimulus(v, 1'b0, $sformatf("rnd%0d", n));
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end
        for (int r = 0; r < 32; r++) check_reg(r, m_regs[r]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
